// File: rtl/bus_master_ctrl.sv
// Bus master control stage: sequences address/data phases over two ping-pong
// register banks, tracks one pending request and reports read data/status.
module bus_master_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [15:0] Abus,
  output logic [31:0] bus_dout,
  output logic        sel1,
  output logic        sel2,
  output logic        sel3,
  output logic        sel4,
  output logic        mux1,
  output logic        mux2,
  output logic        Aout,
  output logic        Dout,
  input  logic [31:0] bus_din,
  input  logic        rdyout,
  input  logic [1:0]  respout,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready never depends on req_valid. rsp_valid is a one-cycle pulse with no
  // back-pressure.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    state;
  logic          wr_ptr;
  logic          cur_bank;
  logic          cur_write;
  logic          pend_valid;
  logic          pend_bank;
  logic          pend_write;
  logic [CW-1:0] wait_cnt;

  logic accept;
  logic last_wait;
  logic done;
  logic timed_out;

  assign req_ready = !rst && (state == S_IDLE || !pend_valid);
  assign accept    = req_valid && req_ready;
  assign last_wait = (wait_cnt == CNT_LAST);
  assign done      = (state == S_DATA) && (rdyout || last_wait);
  assign timed_out = (state == S_DATA) && !rdyout && last_wait;

  assign Abus      = req_addr;
  assign bus_dout  = req_wdata;
  assign busy      = (state != S_IDLE) || pend_valid;
  assign dbg_state = state;

  // Banks are loaded on the accept edge, so the write pointer picks the target.
  assign sel1 = accept && !wr_ptr;
  assign sel2 = accept && wr_ptr;
  assign sel3 = accept && !wr_ptr && req_write;
  assign sel4 = accept && wr_ptr && req_write;

  always_comb begin
    mux1 = 1'b0;
    mux2 = 1'b0;
    Aout = 1'b0;
    Dout = 1'b0;
    if (!rst) begin
      case (state)
        S_ADDR: begin
          mux1 = cur_bank;
          Aout = 1'b1;
        end
        S_DATA: begin
          mux1 = cur_bank;
          Aout = 1'b1;
          mux2 = cur_bank;
          Dout = cur_write;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= 1'b0;
      cur_bank    <= 1'b0;
      cur_write   <= 1'b0;
      pend_valid  <= 1'b0;
      pend_bank   <= 1'b0;
      pend_write  <= 1'b0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= done;
      rsp_err     <= timed_out || (done && rdyout && respout != 2'b00);
      rsp_timeout <= timed_out;
      rsp_rdata   <= (done && rdyout && !cur_write && respout == 2'b00) ? bus_din : 32'h0;

      if (accept) wr_ptr <= ~wr_ptr;

      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_bank  <= wr_ptr;
            cur_write <= req_write;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          state <= S_DATA;
          if (accept) begin
            pend_valid <= 1'b1;
            pend_bank  <= wr_ptr;
            pend_write <= req_write;
          end
        end
        S_DATA: begin
          if (done) begin
            wait_cnt <= '0;
            if (pend_valid) begin
              cur_bank   <= pend_bank;
              cur_write  <= pend_write;
              pend_valid <= 1'b0;
              state      <= S_ADDR;
            end else if (accept) begin
              // Request arriving on the completion edge skips the pending slot.
              cur_bank  <= wr_ptr;
              cur_write <= req_write;
              state     <= S_ADDR;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (accept) begin
              pend_valid <= 1'b1;
              pend_bank  <= wr_ptr;
              pend_write <= req_write;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
